// File: rtl/fi_campaign_if.sv
// fi_campaign_if: campaign config, control and progress signals
// between control logic and the fault-injection sequencer.
interface fi_campaign_if #(
  parameter int N     = 4,
  parameter int CNT_W = 16,
  parameter int REP_W = 8
);
  localparam int LW = $clog2(N);

  logic             start_i;
  logic             abort_i;
  logic [LW-1:0]    lane_sel_i;
  logic [CNT_W-1:0] delay_i;
  logic [CNT_W-1:0] width_i;
  logic [CNT_W-1:0] gap_i;
  logic [REP_W-1:0] repeat_i;
  logic [N-1:0]     inj_en_o;
  logic             busy_o;
  logic             done_o;
  logic [REP_W-1:0] inj_count_o;

  modport master (
    output start_i, abort_i, lane_sel_i,
    output delay_i, width_i, gap_i, repeat_i,
    input  inj_en_o, busy_o, done_o, inj_count_o
  );

  modport slave (
    input  start_i, abort_i, lane_sel_i,
    input  delay_i, width_i, gap_i, repeat_i,
    output inj_en_o, busy_o, done_o, inj_count_o
  );
endinterface

// File: rtl/fi_campaign_ctrl.sv
// fi_campaign_ctrl: cycle-exact fault-injection campaign sequencer.
// Define FI_CAMPAIGN_LFSR_EN to add LFSR jitter to each gap.
module fi_campaign_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input logic         clk_i,
  input logic         rstn,
  fi_campaign_if.slave bus
);
  localparam int LW = $clog2(N);
  localparam logic [LW:0] NL = (LW+1)'(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
`ifdef FI_CAMPAIGN_LFSR_EN
  // one spare bit so max gap plus jitter never wraps
  localparam int CW = CNT_W + 1;
`else
  localparam int CW = CNT_W;
`endif

  typedef enum logic [2:0] {
    IDLE, DELAY, INJECT, GAP, DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    gap_load;
  logic [CW-1:0]    width_load;
  logic [CNT_W-1:0] gmax;
  logic [LW-1:0]    lane_q;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] gap_q;
  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rmax;
  logic [REP_W-1:0] count;
  logic [N-1:0]     inj_en;
  logic [N-1:0]     lane_oh;
  logic             busy;
  logic             done;
  logic             last;
  logic             start_ok;

  always_comb begin
    rmax       = (rep_q == '0) ? REP_W'(1) : rep_q;
    gmax       = (gap_q == '0) ? CNT_W'(1) : gap_q;
    lane_oh    = ONE << lane_q;
    last       = (cnt == '0);
    width_load = CW'(width_q) - CW'(1);
    start_ok   = bus.start_i &&
                 ({1'b0, bus.lane_sel_i} < NL);
  end

`ifdef FI_CAMPAIGN_LFSR_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0],
                  lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb
    gap_load = CW'(gmax) - CW'(1) + CW'(lfsr[3:0]);
`else
  always_comb
    gap_load = CW'(gmax) - CW'(1);
`endif

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      lane_q  <= '0;
      width_q <= '0;
      gap_q   <= '0;
      rep_q   <= '0;
      count   <= '0;
      inj_en  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.abort_i) begin
        // a pulse ending on the abort edge still counts
        if (state == INJECT && last)
          count <= count + REP_W'(1);
        state  <= IDLE;
        inj_en <= '0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_ok) begin
              lane_q  <= bus.lane_sel_i;
              width_q <= bus.width_i;
              gap_q   <= bus.gap_i;
              rep_q   <= bus.repeat_i;
              cnt     <= CW'(bus.delay_i);
              count   <= '0;
              busy    <= 1'b1;
              if (bus.width_i == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= DELAY;
              end
            end
          end
          DELAY: begin
            if (last) begin
              state  <= INJECT;
              inj_en <= lane_oh;
              cnt    <= width_load;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          INJECT: begin
            if (last) begin
              inj_en <= '0;
              count  <= count + REP_W'(1);
              if ((count + REP_W'(1)) == rmax) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= GAP;
                cnt   <= gap_load;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          GAP: begin
            if (last) begin
              state  <= INJECT;
              inj_en <= lane_oh;
              cnt    <= width_load;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.inj_en_o    = inj_en;
  assign bus.busy_o      = busy;
  assign bus.done_o      = done;
  assign bus.inj_count_o = count;
endmodule
